// File: rtl/bank_port_arbiter.sv
// bank_port_arbiter
//   Shares a dual-bank operand memory between two requesters. Requester 0 is
//   instruction fetch and requester 1 is operand/data access. Address bit 0
//   selects the bank: the even bank is port A and the odd bank is port B.
//   Each bank is granted to at most one requester per cycle. A same-bank
//   conflict is resolved by a per-bank round-robin pointer, or in favour of
//   requester 0 when FIXED_PRI is set. Bank commands are registered one-cycle
//   strobes. Read data is routed back to the requester that owns it once the
//   memory read latency has elapsed.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   rX_valid/ready                 request handshake (ready is combinational)
//   rX_addr/we/wdata               request address, write flag, write data
//   rX_rsp_valid/rsp_data          one-cycle read response
//   mar_load_*/mar_in_*            MAR load strobe and address per bank
//   mem_oe_*/mem_ld_*/wdata_*      bank read enable, write enable, write data
//   rdata_*                        bank read data
//   conflict_cnt                   saturating count of conflict cycles
module bank_port_arbiter #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r0_we,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_data,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic              r1_we,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_data,

    output logic              mar_load_a,
    output logic              mar_load_b,
    output logic [ADDR_W-1:0] mar_in_a,
    output logic [ADDR_W-1:0] mar_in_b,
    output logic              mem_oe_a,
    output logic              mem_oe_b,
    output logic              mem_ld_a,
    output logic              mem_ld_b,
    output logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] wdata_b,
    input  logic [DATA_W-1:0] rdata_a,
    input  logic [DATA_W-1:0] rdata_b,

    output logic [7:0]        conflict_cnt
);

    // Per-bank round-robin pointer: 0 favours requester 0, 1 favours requester 1.
    logic [1:0] ptr_q;
    logic [7:0] cnt_q;

    // Registered command strobes, index 0 = bank A (even), 1 = bank B (odd).
    logic [1:0]        mar_load_q;
    logic [1:0]        oe_q;
    logic [1:0]        ld_q;
    logic [1:0]        cmd_id_q;
    logic [ADDR_W-1:0] mar_in_q [2];
    logic [DATA_W-1:0] wdata_q  [2];

    // Response pipeline per bank: valid and requester tag.
    logic [RD_LAT-1:0] pv_q  [2];
    logic [RD_LAT-1:0] pid_q [2];

    // Arbitration
    logic conflict;
    logic r1_wins;
    logic g0;
    logic g1;

    always_comb begin
        conflict = r0_valid & r1_valid & (r0_addr[0] == r1_addr[0]);
        r1_wins  = FIXED_PRI ? 1'b0 : ptr_q[r0_addr[0]];
        r0_ready = rst_n & r0_valid & ~(conflict & r1_wins);
        r1_ready = rst_n & r1_valid & ~(conflict & ~r1_wins);
        g0       = r0_valid & r0_ready;
        g1       = r1_valid & r1_ready;
    end

    // Per-bank issue decode. A handshake targets exactly one bank, and at
    // most one requester is granted a given bank, so the selects are exclusive.
    logic [1:0]        sel_r0;
    logic [1:0]        sel_r1;
    logic [1:0]        issue;
    logic [1:0]        iss_we;
    logic [ADDR_W-1:0] iss_addr  [2];
    logic [DATA_W-1:0] iss_wdata [2];

    always_comb begin
        sel_r0 = {g0 & r0_addr[0], g0 & ~r0_addr[0]};
        sel_r1 = {g1 & r1_addr[0], g1 & ~r1_addr[0]};
        issue  = sel_r0 | sel_r1;
        iss_we = (sel_r0 & {2{r0_we}}) | (sel_r1 & {2{r1_we}});
        for (int b = 0; b < 2; b++) begin
            iss_addr[b]  = sel_r1[b] ? r1_addr  : r0_addr;
            iss_wdata[b] = sel_r1[b] ? r1_wdata : r0_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= 2'b00;
            cnt_q      <= 8'd0;
            mar_load_q <= 2'b00;
            oe_q       <= 2'b00;
            ld_q       <= 2'b00;
            cmd_id_q   <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                mar_in_q[b] <= '0;
                wdata_q[b]  <= '0;
                pv_q[b]     <= '0;
                pid_q[b]    <= '0;
            end
        end else begin
            // After a conflict the winner yields the bank to the other side.
            if (conflict) begin
                ptr_q[r0_addr[0]] <= ~r1_wins;
            end
            if (conflict && (cnt_q != 8'hff)) begin
                cnt_q <= cnt_q + 8'd1;
            end

            mar_load_q <= issue;
            oe_q       <= issue & ~iss_we;
            ld_q       <= issue & iss_we;
            cmd_id_q   <= sel_r1;
            for (int b = 0; b < 2; b++) begin
                if (issue[b]) begin
                    mar_in_q[b] <= iss_addr[b];
                end
                if (issue[b] && iss_we[b]) begin
                    wdata_q[b] <= iss_wdata[b];
                end
                // Loaded from the issued read strobe so the tap lines up with
                // bank data RD_LAT cycles after the command.
                pv_q[b][0]  <= oe_q[b];
                pid_q[b][0] <= cmd_id_q[b];
                for (int i = 1; i < int'(RD_LAT); i++) begin
                    pv_q[b][i]  <= pv_q[b][i-1];
                    pid_q[b][i] <= pid_q[b][i-1];
                end
            end
        end
    end

    // Response routing at the pipeline tap
    logic tap_a0;
    logic tap_a1;
    logic tap_b0;
    logic tap_b1;

    always_comb begin
        tap_a0 = pv_q[0][RD_LAT-1] & ~pid_q[0][RD_LAT-1];
        tap_a1 = pv_q[0][RD_LAT-1] &  pid_q[0][RD_LAT-1];
        tap_b0 = pv_q[1][RD_LAT-1] & ~pid_q[1][RD_LAT-1];
        tap_b1 = pv_q[1][RD_LAT-1] &  pid_q[1][RD_LAT-1];

        r0_rsp_valid = tap_a0 | tap_b0;
        r1_rsp_valid = tap_a1 | tap_b1;

        r0_rsp_data = '0;
        if (tap_a0) begin
            r0_rsp_data = rdata_a;
        end else if (tap_b0) begin
            r0_rsp_data = rdata_b;
        end

        r1_rsp_data = '0;
        if (tap_a1) begin
            r1_rsp_data = rdata_a;
        end else if (tap_b1) begin
            r1_rsp_data = rdata_b;
        end
    end

    assign mar_load_a   = mar_load_q[0];
    assign mar_load_b   = mar_load_q[1];
    assign mar_in_a     = mar_in_q[0];
    assign mar_in_b     = mar_in_q[1];
    assign mem_oe_a     = oe_q[0];
    assign mem_oe_b     = oe_q[1];
    assign mem_ld_a     = ld_q[0];
    assign mem_ld_b     = ld_q[1];
    assign wdata_a      = wdata_q[0];
    assign wdata_b      = wdata_q[1];
    assign conflict_cnt = cnt_q;

endmodule

// File: doc/bank_port_arbiter.md
Name: bank_port_arbiter

Overview:
- Shares the dual-bank operand memory (even bank on MAR/port A, odd bank on MAR/port B, bank = address bit 0) between two requesters: requester 0 (instruction fetch) and requester 1 (operand/data access).
- Each cycle, each bank is granted to at most one requester. Conflicts are resolved per bank by round-robin, or by fixed priority when configured.
- The block drives registered one-cycle MAR load, output-enable and load strobes to each bank, then routes read data back to the owning requester after the memory read latency.

Parameters:
- ADDR_W, 4, address width; bit 0 selects the bank.
- DATA_W, 8, memory data width.
- RD_LAT, 1, cycles from the bank command strobe to valid bank read data (1..4).
- FIXED_PRI, 0, 0 = round-robin per bank; 1 = requester 0 always wins a conflict.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- r0_valid / r1_valid  in  1  request valid; held until accepted.
- r0_ready / r1_ready  out  1  combinational grant; handshake = valid & ready at the clock edge.
- r0_addr / r1_addr  in  ADDR_W  request address.
- r0_we / r1_we  in  1  1 = write, 0 = read.
- r0_wdata / r1_wdata  in  DATA_W  write data.
- r0_rsp_valid / r1_rsp_valid  out  1  one-cycle pulse: read data valid.
- r0_rsp_data / r1_rsp_data  out  DATA_W  read data.
- mar_load_a / mar_load_b  out  1  MAR load strobe for the even / odd bank.
- mar_in_a / mar_in_b  out  ADDR_W  full address presented to the MAR.
- mem_oe_a / mem_oe_b  out  1  bank read enable.
- mem_ld_a / mem_ld_b  out  1  bank write enable.
- wdata_a / wdata_b  out  DATA_W  bank write data.
- rdata_a / rdata_b  in  DATA_W  bank read data.
- conflict_cnt  out  8  saturating count of conflict cycles.

Behaviour:
- Reset (rst_n=0 at the edge):
  - All strobes, rsp_valid and conflict_cnt go to 0.
  - mar_in_*, wdata_* and rsp_data go to 0.
  - Both per-bank round-robin pointers favour requester 0.
  - The response pipeline is flushed; in-flight reads are dropped with no rsp pulse.
  - While rst_n=0, both ready outputs are 0.
- Arbitration (combinational):
  - Target bank of rX = rX_addr[0].
  - Different banks or a single valid: every valid is ready.
  - Same bank: the winner is given by the pointer (or requester 0 if FIXED_PRI=1); the loser's ready=0.
- Pointer update: on a conflict grant, that bank's pointer moves to favour the other requester. Non-conflict grants leave the pointer unchanged.
- Command issue, registered, in the cycle after the handshake:
  - The bank's mar_load=1 and mar_in=addr.
  - Read: mem_oe=1. Write: mem_ld=1 and wdata=data.
  - Strobes default to 0 each cycle and are never asserted for more than one cycle per grant. mar_in/wdata hold their last value when idle.
- Response pipeline:
  - Per bank, an RD_LAT-deep shift register of {valid, requester id}, loaded when a read command issues.
  - At the tap, the bank's rdata is routed to rsp_data of the tagged requester and that requester's rsp_valid pulses.
  - Latency from handshake to rsp_valid is RD_LAT+1 cycles.
  - A requester wins at most one bank per cycle, so responses never collide. Writes produce no response.
- Throughput: two accesses per cycle when the banks differ. A conflicting loser waits at least one cycle; with round-robin it is guaranteed a grant on the next cycle if it stays valid.
- conflict_cnt increments on each cycle with both valid and the same bank, and saturates at 255.
- Reset asserted mid-operation: takes effect at the next edge and overrides any issue or response.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with both valids high -> ready=0, all strobes 0, conflict_cnt=0. Release -> first grants follow.
- No conflict: r0 read addr 4, r1 read addr 7 in the same cycle -> both ready. Next cycle: mar_in_a=4 and mar_in_b=7 with both oe=1. With RD_LAT=1 and rdata_a=0x11, rdata_b=0x22, two cycles after the handshake: r0_rsp_data=0x11 and r1_rsp_data=0x22 pulse together.
- Conflict round-robin: r0 addr 2 and r1 addr 6 held valid for 3 cycles -> grants r0, r1, r0 on even bank. r1 receives 0x00 data tag correctly. conflict_cnt=3.
- FIXED_PRI=1: same stimulus -> r0 granted every cycle, r1_ready stays 0.
- Write: r1 write addr 5, data 0xA5 -> next cycle mem_ld_b=1, mar_in_b=5, wdata_b=0xA5, no rsp pulse. Pulse rst_n=0 for one cycle between a read handshake and its response -> no rsp_valid occurs.
- Saturation: 300 consecutive conflict cycles -> conflict_cnt stays at 255.
